// File: rtl/rib_timer_pkg.sv
// Shared definitions for the rib_timer peripheral: register offsets
// (decoded from addr[3:2]) and the bit positions inside the CTRL register.
package rib_timer_pkg;

   typedef enum logic [1:0] {
      REG_CTRL   = 2'd0,
      REG_COUNT  = 2'd1,
      REG_CMP    = 2'd2,
      REG_STATUS = 2'd3
   } reg_off_e;

   localparam int CTRL_EN        = 0;
   localparam int CTRL_IE        = 1;
   localparam int CTRL_PEND      = 2;
   localparam int CTRL_ONESHOT   = 3;
   localparam int CTRL_PRESC_LSB = 8;

endpackage

// File: rtl/rib_timer_prescaler.sv
// Prescaler for rib_timer: counts up while enabled and produces a one-cycle
// tick whenever the count reaches the reload value, then restarts from 0.
// When disabled the count is held at 0 so a fresh enable starts a full period.
module rib_timer_prescaler #(
   parameter int PRESC_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [PRESC_W-1:0] presc,
   output logic               tick,
   output logic [PRESC_W-1:0] pcnt
);

   logic [PRESC_W-1:0] pcnt_q;
   logic [PRESC_W-1:0] pcnt_d;
   logic               wrapHit;

   assign wrapHit = (pcnt_q == presc);
   assign tick    = en && wrapHit;
   assign pcnt    = pcnt_q;

   // Next prescaler count: hold at 0 while disabled, restart on a tick.
   always_comb begin
      pcnt_d = pcnt_q;
      if (!en || wrapHit) begin
         pcnt_d = '0;
      end else begin
         pcnt_d = pcnt_q + {{(PRESC_W-1){1'b0}}, 1'b1};
      end
   end

   // Prescaler count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_d;
      end
   end

endmodule

// File: rtl/rib_timer.sv
// rib_timer: zero-wait-state bus timer with a prescaled 32-bit up-counter,
// a compare register and a registered level interrupt. Bus writes always
// take priority over hardware updates, except that a hardware PEND set beats
// a software PEND clear so no compare event is ever lost.
module rib_timer
   import rib_timer_pkg::*;
#(
   parameter int          PRESC_W = 8,
   parameter logic [31:0] CMP_RST = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_i,
   input  logic        wr_en_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        int_sig_o
);

   logic               en_q, en_d;
   logic               ie_q, ie_d;
   logic               pend_q, pend_d;
   logic               oneshot_q, oneshot_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [31:0]        count_q, count_d;
   logic [31:0]        cmp_q, cmp_d;
   logic               int_q, int_d;

   logic               tick;
   logic [PRESC_W-1:0] pcnt;
   reg_off_e           regOff;
   logic               wrCtrl, wrCount, wrCmp;
   logic               tickEff;
   logic               cmpHit;
   logic               unusedAddr;

   assign regOff     = reg_off_e'(addr_i[3:2]);
   assign unusedAddr = ^{addr_i[31:4], addr_i[1:0]};
   assign wrCtrl     = req_i && wr_en_i && (regOff == REG_CTRL);
   assign wrCount    = req_i && wr_en_i && (regOff == REG_COUNT);
   assign wrCmp      = req_i && wr_en_i && (regOff == REG_CMP);

   // A CTRL write that clears EN suppresses a tick landing in the same cycle.
   assign tickEff = tick && !(wrCtrl && !data_i[CTRL_EN]);
   assign cmpHit  = tickEff && (count_q >= cmp_q);

   rib_timer_prescaler #(
      .PRESC_W(PRESC_W)
   ) u_prescaler (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en_q),
      .presc(presc_q),
      .tick (tick),
      .pcnt (pcnt)
   );

   // Next-state for the register file: hardware tick effects first, then bus
   // writes override, with the PEND set protected against a same-cycle clear.
   always_comb begin
      en_d      = en_q;
      ie_d      = ie_q;
      pend_d    = pend_q;
      oneshot_d = oneshot_q;
      presc_d   = presc_q;
      count_d   = count_q;
      cmp_d     = cmp_q;
      int_d     = pend_q && ie_q;

      if (tickEff) begin
         if (cmpHit) begin
            count_d = '0;
         end else begin
            count_d = count_q + 32'd1;
         end
      end

      if (cmpHit) begin
         pend_d = 1'b1;
         if (oneshot_q) begin
            en_d = 1'b0;
         end
      end

      if (wrCtrl) begin
         en_d      = data_i[CTRL_EN];
         ie_d      = data_i[CTRL_IE];
         oneshot_d = data_i[CTRL_ONESHOT];
         presc_d   = data_i[CTRL_PRESC_LSB +: PRESC_W];
         if (data_i[CTRL_PEND] && !cmpHit) begin
            pend_d = 1'b0;
         end
      end

      if (wrCount) begin
         count_d = data_i;
      end

      if (wrCmp) begin
         cmp_d = data_i;
      end
   end

   // Register file and interrupt output flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q      <= 1'b0;
         ie_q      <= 1'b0;
         pend_q    <= 1'b0;
         oneshot_q <= 1'b0;
         presc_q   <= '0;
         count_q   <= '0;
         cmp_q     <= CMP_RST;
         int_q     <= 1'b0;
      end else begin
         en_q      <= en_d;
         ie_q      <= ie_d;
         pend_q    <= pend_d;
         oneshot_q <= oneshot_d;
         presc_q   <= presc_d;
         count_q   <= count_d;
         cmp_q     <= cmp_d;
         int_q     <= int_d;
      end
   end

   assign int_sig_o = int_q;

   // Zero-latency read mux; drives 0 whenever this is not a read access.
   always_comb begin
      data_o = '0;
      if (req_i && !wr_en_i) begin
         case (regOff)
            REG_CTRL: begin
               data_o[CTRL_EN]                      = en_q;
               data_o[CTRL_IE]                      = ie_q;
               data_o[CTRL_PEND]                    = pend_q;
               data_o[CTRL_ONESHOT]                 = oneshot_q;
               data_o[CTRL_PRESC_LSB +: PRESC_W]    = presc_q;
            end
            REG_COUNT:  data_o = count_q;
            REG_CMP:    data_o = cmp_q;
            REG_STATUS: data_o[PRESC_W-1:0] = pcnt;
            default:    data_o = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_rib_timer.sv
// Self-checking bench for rib_timer. A behavioural model of the timer
// (register values, prescaler position, interrupt level) is advanced at
// every rising edge from the same bus inputs the DUT sees.
module tb_rib_timer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_i;
   logic        wr_en_i;
   logic [31:0] addr_i;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic        int_sig_o;

   int nCompared   = 0;
   int nMismatched = 0;

   // Behavioural model state.
   bit          mEn, mIe, mPend, mOneshot, mInt;
   logic [7:0]  mPresc, mPcnt;
   logic [31:0] mCount, mCmp;

   rib_timer #(
      .PRESC_W(8),
      .CMP_RST(32'h0000_0000)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_i    (req_i),
      .wr_en_i  (wr_en_i),
      .addr_i   (addr_i),
      .data_i   (data_i),
      .data_o   (data_o),
      .int_sig_o(int_sig_o)
   );

   always #5 clk = ~clk;

   function automatic void modelReset();
      mEn = 0; mIe = 0; mPend = 0; mOneshot = 0; mInt = 0;
      mPresc = 0; mPcnt = 0; mCount = 0; mCmp = 0;
   endfunction

   function automatic logic [31:0] modelRead(input logic [31:0] a);
      logic [31:0] r;
      r = 32'h0;
      case (a[3:2])
         2'd0: r = {16'h0, mPresc, 4'h0, mOneshot, mPend, mIe, mEn};
         2'd1: r = mCount;
         2'd2: r = mCmp;
         default: r = {24'h0, mPcnt};
      endcase
      return r;
   endfunction

   // One clock edge of the timer, from the timer's rules.
   function automatic void modelStep();
      bit          wrC, wrN, wrP, tickNow, hit;
      int unsigned off;
      logic [7:0]  nPcnt;
      off     = addr_i[3:2];
      wrC     = req_i && wr_en_i && off == 0;
      wrN     = req_i && wr_en_i && off == 1;
      wrP     = req_i && wr_en_i && off == 2;
      tickNow = mEn && (mPcnt == mPresc) && !(wrC && !data_i[0]);
      hit     = tickNow && (mCount >= mCmp);
      nPcnt   = (!mEn || mPcnt == mPresc) ? 8'd0 : mPcnt + 8'd1;
      mInt    = mPend && mIe;
      if (tickNow) mCount = hit ? 32'd0 : mCount + 32'd1;
      if (hit && mOneshot) mEn = 0;
      if (wrC) begin
         mEn      = data_i[0];
         mIe      = data_i[1];
         mOneshot = data_i[3];
         mPresc   = data_i[15:8];
         if (data_i[2]) mPend = 0;
      end
      if (hit) mPend = 1;
      if (wrN) mCount = data_i;
      if (wrP) mCmp = data_i;
      mPcnt = nPcnt;
   endfunction

   task automatic cycle();
      @(posedge clk);
      modelStep();
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic writeReg(input logic [31:0] a, input logic [31:0] d);
      req_i = 1; wr_en_i = 1; addr_i = a; data_i = d;
      cycle();
      req_i = 0; wr_en_i = 0;
   endtask

   task automatic busRead(input logic [31:0] a, output logic [31:0] v);
      req_i = 1; wr_en_i = 0; addr_i = a; data_i = $urandom;
      #1;
      v = data_o;
      cycle();
      req_i = 0;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      rst_n = 0; req_i = 0; wr_en_i = 0; addr_i = 0; data_i = 0;
      modelReset();
      #12;
      rst_n = 1;
      @(posedge clk); #1;
      nCompared++;
      if (int_sig_o !== 1'b0) begin
         nMismatched++; $display("[TB] FAIL reset_int: got %b expected 0", int_sig_o);
      end
      for (int r = 0; r < 4; r++) begin
         busRead(32'(r * 4), v);
         nCompared++;
         if (v !== 32'h0) begin
            nMismatched++; $display("[TB] FAIL reset_reg%0d: got %h expected 0", r, v);
         end
      end
   endtask

   task automatic test_periodic();
      logic [31:0] v;
      logic [31:0] seq [5] = '{0, 1, 2, 3, 0};
      writeReg(32'h8, 32'd3);
      writeReg(32'h0, 32'h3);
      for (int i = 0; i < 5; i++) begin
         busRead(32'h4, v);
         nCompared++;
         if (v !== seq[i]) begin
            nMismatched++; $display("[TB] FAIL periodic_count[%0d]: got %0d expected %0d", i, v, seq[i]);
         end
      end
      nCompared++;
      if (int_sig_o !== 1'b1) begin
         nMismatched++; $display("[TB] FAIL periodic_int_set: got %b expected 1", int_sig_o);
      end
      busRead(32'h0, v);
      nCompared++;
      if (v !== 32'h7) begin
         nMismatched++; $display("[TB] FAIL periodic_ctrl_pend: got %h expected 7", v);
      end
      writeReg(32'h0, 32'h7);
      busRead(32'h0, v);
      nCompared++;
      if (v !== 32'h3) begin
         nMismatched++; $display("[TB] FAIL periodic_ctrl_clr: got %h expected 3", v);
      end
      nCompared++;
      if (int_sig_o !== 1'b0 || int_sig_o !== mInt) begin
         nMismatched++; $display("[TB] FAIL periodic_int_drop: got %b expected 0", int_sig_o);
      end
   endtask

   task automatic test_oneshot();
      logic [31:0] v;
      logic [31:0] seq [8] = '{0, 0, 0, 1, 1, 1, 0, 0};
      writeReg(32'h0, 32'h4);
      writeReg(32'h4, 32'h0);
      writeReg(32'h8, 32'h1);
      writeReg(32'h0, 32'h209);
      for (int i = 0; i < 8; i++) begin
         busRead(32'h4, v);
         nCompared++;
         if (v !== seq[i]) begin
            nMismatched++; $display("[TB] FAIL oneshot_count[%0d]: got %0d expected %0d", i, v, seq[i]);
         end
      end
      busRead(32'h0, v);
      nCompared++;
      if (v !== 32'h20C) begin
         nMismatched++; $display("[TB] FAIL oneshot_ctrl: got %h expected 20c", v);
      end
      idle(5);
      busRead(32'h4, v);
      nCompared++;
      if (v !== 32'h0) begin
         nMismatched++; $display("[TB] FAIL oneshot_hold: got %h expected 0", v);
      end
   endtask

   task automatic test_cmp_below();
      logic [31:0] v;
      writeReg(32'h0, 32'h4);
      writeReg(32'h4, 32'd10);
      writeReg(32'h8, 32'd5);
      writeReg(32'h0, 32'h1);
      busRead(32'h0, v);
      busRead(32'h4, v);
      nCompared++;
      if (v !== 32'h0) begin
         nMismatched++; $display("[TB] FAIL cmp_below_count: got %0d expected 0", v);
      end
      busRead(32'h0, v);
      nCompared++;
      if (v !== 32'h5) begin
         nMismatched++; $display("[TB] FAIL cmp_below_pend: got %h expected 5", v);
      end
      writeReg(32'h4, 32'd7);
      busRead(32'h4, v);
      nCompared++;
      if (v !== 32'd7) begin
         nMismatched++; $display("[TB] FAIL count_write_wins: got %0d expected 7", v);
      end
   endtask

   task automatic test_pend_race();
      logic [31:0] v;
      bit found = 0;
      writeReg(32'h0, 32'h5);
      for (int i = 0; i < 20 && !found; i++) begin
         if (mEn && mPcnt == mPresc && mCount >= mCmp) begin
            writeReg(32'h0, 32'h7);
            found = 1;
         end else begin
            cycle();
         end
      end
      nCompared++;
      if (!found) begin
         nMismatched++; $display("[TB] FAIL pend_race_timeout: got no hit expected hit within 20 cycles");
      end else begin
         busRead(32'h0, v);
         if (v[2] !== 1'b1) begin
            nMismatched++; $display("[TB] FAIL pend_race: got pend %b expected 1", v[2]);
         end
      end
   endtask

   task automatic test_status();
      logic [31:0] v, e;
      writeReg(32'h8, 32'd50);
      writeReg(32'h0, 32'h301);
      idle(2);
      for (int i = 0; i < 4; i++) begin
         e = modelRead(32'h1C);
         busRead(i[0] ? 32'h1C : 32'hC, v);
         nCompared++;
         if (v !== e) begin
            nMismatched++; $display("[TB] FAIL status_pcnt[%0d]: got %h expected %h", i, v, e);
         end
      end
      writeReg(32'h0, 32'h300);
      writeReg(32'hC, 32'hFFFF_FFFF);
      for (int r = 0; r < 4; r++) begin
         e = modelRead(32'(r * 4));
         busRead(32'(r * 4), v);
         nCompared++;
         if (v !== e) begin
            nMismatched++; $display("[TB] FAIL status_write_ignored_reg%0d: got %h expected %h", r, v, e);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] e;
      int unsigned kind;
      writeReg(32'h8, 32'd4);
      for (int i = 0; i < 400; i++) begin
         kind    = $urandom_range(0, 9);
         addr_i  = {$urandom} & 32'hFFFF_FFFC;
         data_i  = $urandom;
         req_i   = (kind >= 3);
         wr_en_i = (kind >= 7) ? 1'b1 : ((kind < 3) ? 1'($urandom) : 1'b0);
         if (kind >= 7) begin
            case (addr_i[3:2])
               2'd0: begin
                  data_i[15:8] = 8'($urandom_range(0, 3));
                  data_i[0]    = ($urandom_range(0, 3) != 0);
               end
               2'd1: data_i = $urandom_range(0, 12);
               2'd2: data_i = $urandom_range(0, 12);
               default: ;
            endcase
         end
         #1;
         e = (req_i && !wr_en_i) ? modelRead(addr_i) : 32'h0;
         nCompared++;
         if (data_o !== e) begin
            nMismatched++; $display("[TB] FAIL random_read[%0d]: got %h expected %h", i, data_o, e);
         end
         cycle();
         nCompared++;
         if (int_sig_o !== mInt) begin
            nMismatched++; $display("[TB] FAIL random_int[%0d]: got %b expected %b", i, int_sig_o, mInt);
         end
      end
      req_i = 0; wr_en_i = 0;
   endtask

   task automatic test_async_reset();
      logic [31:0] v;
      writeReg(32'h0, 32'h4);
      writeReg(32'h8, 32'd0);
      writeReg(32'h0, 32'h3);
      idle(2);
      writeReg(32'h8, 32'd100);
      writeReg(32'h0, 32'h2);
      writeReg(32'h4, 32'd2);
      idle(2);
      nCompared++;
      if (int_sig_o !== 1'b1 || mInt !== 1'b1 || mCount !== 32'd2) begin
         nMismatched++; $display("[TB] FAIL pre_reset_int: got %b expected 1", int_sig_o);
      end
      #2;
      rst_n = 0;
      modelReset();
      #1;
      nCompared++;
      if (int_sig_o !== 1'b0) begin
         nMismatched++; $display("[TB] FAIL async_reset_int: got %b expected 0", int_sig_o);
      end
      req_i = 1; wr_en_i = 0;
      for (int r = 0; r < 4; r++) begin
         addr_i = 32'(r * 4);
         #1;
         nCompared++;
         if (data_o !== 32'h0) begin
            nMismatched++; $display("[TB] FAIL async_reset_reg%0d: got %h expected 0", r, data_o);
         end
      end
      req_i = 0;
      for (int r = 0; r < 4; r++) begin
         addr_i = $urandom;
         #1;
         nCompared++;
         if (data_o !== 32'h0) begin
            nMismatched++; $display("[TB] FAIL idle_bus_data[%0d]: got %h expected 0", r, data_o);
         end
      end
      @(negedge clk);
      rst_n = 1;
      @(posedge clk); #1;
      idle(3);
      busRead(32'h4, v);
      nCompared++;
      if (v !== 32'h0) begin
         nMismatched++; $display("[TB] FAIL post_reset_count: got %h expected 0", v);
      end
   endtask

   initial begin
      test_reset();
      test_periodic();
      test_oneshot();
      test_cmp_below();
      test_pend_race();
      test_status();
      test_random();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
